operand_extender_stage: RTL and testbench

Parametrised, registered successor to the fixed 16-to-32 zero extender that feeds the Russian-Peasant multiplier datapath.
- Accepts an operand pair (A, B) of IN_W bits with a per-transaction extension mode.
- Extends both operands to OUT_W bits and computes sign and zero hints for the multiplier control FSM.
- Buffers results in a 2-entry FIFO behind a valid/ready handshake, so the multiplier can stall without dropping operands.

---
 rtl/operand_extender_stage_if.sv | 29 ++
 rtl/operand_extender_stage.sv | 110 +++++++++++
 tb/tb_operand_extender_stage.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_extender_stage_if.sv
// Handshake bundle between the operand source, the extender stage and the multiplier.
// slave = the extender stage, master = the side that drives operands and consumes results.
interface operand_extender_stage_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_a;
  logic [IN_W-1:0]  in_b;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_a;
  logic [OUT_W-1:0] out_b;
  logic             out_neg;
  logic             out_zero;
  logic             out_err;

  modport slave (
    input  in_valid, in_a, in_b, in_mode, out_ready,
    output in_ready, out_valid, out_a, out_b, out_neg, out_zero, out_err
  );

  modport master (
    output in_valid, in_a, in_b, in_mode, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_neg, out_zero, out_err
  );
endinterface

// File: rtl/operand_extender_stage.sv
// Extends an operand pair to OUT_W bits (zero/sign/magnitude) and buffers the
// result with multiplier hints in a 2-entry FIFO behind a valid/ready handshake.
module operand_extender_stage #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input logic                     clk,
  input logic                     rst,
  operand_extender_stage_if.slave bus
);

  if (IN_W < 2 || IN_W > 63) begin : g_bad_in_w
    $error("operand_extender_stage: IN_W must be in 2..63");
  end
  if (OUT_W <= IN_W || OUT_W > 64) begin : g_bad_out_w
    $error("operand_extender_stage: OUT_W must satisfy IN_W < OUT_W <= 64");
  end

  localparam int EXT_W = OUT_W - IN_W;

  typedef struct packed {
    logic [OUT_W-1:0] a;
    logic [OUT_W-1:0] b;
    logic             neg;
    logic             zero;
    logic             err;
  } entry_t;

  entry_t          mem_q [2];
  entry_t          new_entry;
  entry_t          head;
  logic [1:0]      count_q, count_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic            push, pop;
  logic            a_neg, b_neg, any_zero;
  logic [IN_W-1:0] a_mag, b_mag;

  // in_ready depends only on registered count and rst, never on out_ready
  assign bus.in_ready  = (count_q != 2'd2) & ~rst;
  assign bus.out_valid = (count_q != 2'd0);
  assign push          = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;

  always_comb begin
    a_neg    = bus.in_a[IN_W-1];
    b_neg    = bus.in_b[IN_W-1];
    any_zero = (bus.in_a == '0) | (bus.in_b == '0);
    // -2^(IN_W-1) negates to itself, which read unsigned is the correct magnitude
    a_mag    = a_neg ? (~bus.in_a + IN_W'(1)) : bus.in_a;
    b_mag    = b_neg ? (~bus.in_b + IN_W'(1)) : bus.in_b;

    new_entry      = '0;
    new_entry.zero = any_zero;
    case (bus.in_mode)
      2'b01: begin
        new_entry.a = {{EXT_W{a_neg}}, bus.in_a};
        new_entry.b = {{EXT_W{b_neg}}, bus.in_b};
      end
      2'b10: begin
        new_entry.a   = {{EXT_W{1'b0}}, a_mag};
        new_entry.b   = {{EXT_W{1'b0}}, b_mag};
        new_entry.neg = (a_neg ^ b_neg) & ~any_zero;
      end
      2'b11: begin
        new_entry.a   = {{EXT_W{1'b0}}, bus.in_a};
        new_entry.b   = {{EXT_W{1'b0}}, bus.in_b};
        new_entry.err = 1'b1;
      end
      default: begin
        new_entry.a = {{EXT_W{1'b0}}, bus.in_a};
        new_entry.b = {{EXT_W{1'b0}}, bus.in_b};
      end
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push) mem_q[wr_ptr_q] <= new_entry;
    end
  end

  assign head         = mem_q[rd_ptr_q];
  assign bus.out_a    = head.a;
  assign bus.out_b    = head.b;
  assign bus.out_neg  = head.neg;
  assign bus.out_zero = head.zero;
  assign bus.out_err  = head.err;

endmodule

// File: tb/tb_operand_extender_stage.sv
// Scoreboard bench for operand_extender_stage: directed cases plus randomized traffic
// with random consumer backpressure, checked against an arithmetic reference model.
module tb_operand_extender_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  operand_extender_stage_if #(.IN_W(16), .OUT_W(32)) bus ();

  operand_extender_stage #(.IN_W(16), .OUT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        neg;
    logic        zero;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_pops = 0;
  bit   rand_ready = 1'b0;

  task automatic check(string name, logic [71:0] act, logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: interpret operands as integers and apply the mode rules directly
  function automatic exp_t model(logic [15:0] a, logic [15:0] b, logic [1:0] m);
    exp_t   e;
    longint sa;
    longint sb;
    sa = a[15] ? longint'(a) - 65536 : longint'(a);
    sb = b[15] ? longint'(b) - 65536 : longint'(b);
    e.zero = (a == 16'd0) || (b == 16'd0);
    e.err  = (m == 2'b11);
    e.neg  = 1'b0;
    case (m)
      2'b01: begin
        e.a = 32'(sa);
        e.b = 32'(sb);
      end
      2'b10: begin
        e.a   = 32'((sa < 0) ? -sa : sa);
        e.b   = 32'((sb < 0) ? -sb : sb);
        e.neg = ((sa < 0) != (sb < 0)) && !e.zero;
      end
      default: begin
        e.a = 32'(a);
        e.b = 32'(b);
      end
    endcase
    return e;
  endfunction

  logic [66:0] prev_head;
  logic [66:0] cur_head;
  bit          prev_stall = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    cur_head = {bus.out_a, bus.out_b, bus.out_neg, bus.out_zero, bus.out_err};
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && bus.out_valid) check("head_stable", 72'(cur_head), 72'(prev_head));
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL spurious_output: got a=0x%0h b=0x%0h with no expected entry", bus.out_a, bus.out_b);
        end else begin
          e = sb_q.pop_front();
          check("out_a", 72'(bus.out_a), 72'(e.a));
          check("out_b", 72'(bus.out_b), 72'(e.b));
          check("out_neg", 72'(bus.out_neg), 72'(e.neg));
          check("out_zero", 72'(bus.out_zero), 72'(e.zero));
          check("out_err", 72'(bus.out_err), 72'(e.err));
          n_pops++;
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_head  = cur_head;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Offers a pair; records its expectation at the negedge where acceptance is certain
  task automatic send(logic [15:0] a, logic [15:0] b, logic [1:0] m, output int stalls);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_mode  = m;
    stalls       = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb_q.push_back(model(a, b, m));
        break;
      end
      stalls++;
      if (stalls > 200) begin
        n_cmp++;
        n_err++;
        $display("FAIL send_timeout: in_ready low for %0d cycles, required 1", stalls);
        break;
      end
      tick();
    end
    tick();
  endtask

  // Empty FIFO, consumer ready: result must appear the very next cycle with these literal values
  task automatic send_and_expect(logic [15:0] a, logic [15:0] b, logic [1:0] m,
                                 logic [31:0] ea, logic [31:0] eb,
                                 logic en, logic ez, logic ee);
    int st;
    send(a, b, m, st);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("lat_valid", 72'(bus.out_valid), 72'(1'b1));
    check("lit_a", 72'(bus.out_a), 72'(ea));
    check("lit_b", 72'(bus.out_b), 72'(eb));
    check("lit_neg", 72'(bus.out_neg), 72'(en));
    check("lit_zero", 72'(bus.out_zero), 72'(ez));
    check("lit_err", 72'(bus.out_err), 72'(ee));
    tick();
  endtask

  function automatic logic [15:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'h8000;
      2:       return 16'hFFFF;
      3:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int st_sum;
    int pops0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_mode   = 2'b00;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 72'(bus.out_valid), 72'(1'b0));
    check("rst_in_ready", 72'(bus.in_ready), 72'(1'b0));
    check("rst_out_a", 72'(bus.out_a), 72'(32'h0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 72'(bus.in_ready), 72'(1'b1));
    tick();

    send_and_expect(16'h8001, 16'h0003, 2'b00, 32'h00008001, 32'h00000003, 1'b0, 1'b0, 1'b0);
    send_and_expect(16'hFFFE, 16'h7FFF, 2'b01, 32'hFFFFFFFE, 32'h00007FFF, 1'b0, 1'b0, 1'b0);
    send_and_expect(16'hFFFD, 16'h0005, 2'b10, 32'h00000003, 32'h00000005, 1'b1, 1'b0, 1'b0);
    send_and_expect(16'h8000, 16'h8000, 2'b10, 32'h00008000, 32'h00008000, 1'b0, 1'b0, 1'b0);
    send_and_expect(16'hFFFF, 16'h0000, 2'b10, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1'b0);
    send_and_expect(16'hFFFF, 16'h1234, 2'b11, 32'h0000FFFF, 32'h00001234, 1'b0, 1'b0, 1'b1);

    // Backpressure: two accepted, third refused until the consumer drains
    bus.out_ready = 1'b0;
    send(16'h1111, 16'h2222, 2'b00, st);
    check("bp_p0_stalls", 72'(st), 72'(0));
    send(16'hF333, 16'h0444, 2'b01, st);
    check("bp_p1_stalls", 72'(st), 72'(0));
    bus.in_valid = 1'b1;
    bus.in_a     = 16'h8555;
    bus.in_b     = 16'h0666;
    bus.in_mode  = 2'b10;
    @(negedge clk);
    check("bp_full_in_ready", 72'(bus.in_ready), 72'(1'b0));
    check("bp_full_out_valid", 72'(bus.out_valid), 72'(1'b1));
    repeat (3) tick();
    bus.out_ready = 1'b1;
    send(16'h8555, 16'h0666, 2'b10, st);
    bus.in_valid = 1'b0;
    repeat (4) tick();
    check("bp_drained", 72'(sb_q.size()), 72'(0));

    // Streaming at count=1: one pair in and one out every cycle
    pops0  = n_pops;
    st_sum = 0;
    for (int i = 0; i < 11; i++) begin
      send(16'($urandom), 16'($urandom), 2'($urandom_range(0, 2)), st);
      st_sum += st;
    end
    bus.in_valid = 1'b0;
    check("stream_stalls", 72'(st_sum), 72'(0));
    check("stream_pops_in_flight", 72'(n_pops - pops0), 72'(10));
    repeat (2) tick();
    check("stream_pops", 72'(n_pops - pops0), 72'(11));

    // Mid-stream reset with two entries buffered
    bus.out_ready = 1'b0;
    send(16'hABCD, 16'h0001, 2'b00, st);
    send(16'h1234, 16'h5678, 2'b11, st);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("mrst_in_ready_hi", 72'(bus.in_ready), 72'(1'b0));
    @(posedge clk);
    @(negedge clk);
    check("mrst_out_valid", 72'(bus.out_valid), 72'(1'b0));
    check("mrst_in_ready", 72'(bus.in_ready), 72'(1'b0));
    check("mrst_out_a", 72'(bus.out_a), 72'(32'h0));
    sb_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("mrst_in_ready_after", 72'(bus.in_ready), 72'(1'b1));
    check("mrst_no_stale", 72'(bus.out_valid), 72'(1'b0));
    repeat (4) tick();

    // Randomized traffic with random consumer backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(rand_op(), rand_op(), 2'($urandom_range(0, 3)), st);
      if ($urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        tick();
      end
    end
    bus.in_valid  = 1'b0;
    rand_ready    = 1'b0;
    bus.out_ready = 1'b1;
    repeat (6) tick();
    check("final_drained", 72'(sb_q.size()), 72'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
